// File: rtl/ext_arbiter_pkg.sv
// Shared definitions for the two-requester immediate-extension arbiter:
// extension op codes and output-stage FSM state encodings.
package ext_arbiter_pkg;

  localparam logic [1:0] EOP_SEXT = 2'b00;  // sign-extend
  localparam logic [1:0] EOP_ZEXT = 2'b01;  // zero-extend
  localparam logic [1:0] EOP_LUI  = 2'b10;  // immediate into upper half
  localparam logic [1:0] EOP_BR   = 2'b11;  // sign-extended word offset, x4

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FULL = 1'b1
  } state_e;

endpackage

// File: rtl/ext_arbiter_imm_ext.sv
// imm_ext_unit: combinational immediate extender, (imm, eop) -> DATA_W result.
// The op set assumes DATA_W == 2*IMM_W (16 -> 32 in this revision).
module imm_ext_unit
  import ext_arbiter_pkg::*;
#(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32
) (
  input  logic [IMM_W-1:0]  imm_i,
  input  logic [1:0]        eop_i,
  output logic [DATA_W-1:0] ext_o
);

  logic [DATA_W-1:0] sext;

  assign sext = {{(DATA_W-IMM_W){imm_i[IMM_W-1]}}, imm_i};

  // Select the extension flavour; all four codes are legal.
  always_comb begin
    ext_o = sext;
    case (eop_i)
      EOP_SEXT: ext_o = sext;
      EOP_ZEXT: ext_o = {{(DATA_W-IMM_W){1'b0}}, imm_i};
      EOP_LUI:  ext_o = DATA_W'({imm_i, {IMM_W{1'b0}}});
      EOP_BR:   ext_o = DATA_W'({sext, 2'b00});
      default:  ext_o = sext;
    endcase
  end

endmodule

// File: rtl/ext_arbiter.sv
// ext_arbiter: round-robin share of one immediate extender between two
// requesters, feeding a one-deep registered output stage tagged with the
// winner's ID. The stage reloads in the cycle it drains (1 result/cycle).
// Optional build macro EXT_ARB_STATS_EN adds saturating per-requester
// transfer counters on grant_cnt0/grant_cnt1.
module ext_arbiter
  import ext_arbiter_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [IMM_W-1:0]  req0_imm,
  input  logic [1:0]        req0_eop,
  input  logic [IMM_W-1:0]  req1_imm,
  input  logic [1:0]        req1_eop,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
`ifdef EXT_ARB_STATS_EN
  output logic [15:0]       grant_cnt0,
  output logic [15:0]       grant_cnt1,
`endif
  output logic              out_id
);

  state_e            state_q;
  logic              ptr_q;        // requester holding priority on contention
  logic [DATA_W-1:0] out_data_q;
  logic              out_id_q;

  logic              can_load;
  logic              win;
  logic              xfer;
  logic [NREQ-1:0]   grant;
  logic [IMM_W-1:0]  sel_imm;
  logic [1:0]        sel_eop;
  logic [DATA_W-1:0] ext_res;

  // Grant: a lone requester wins outright, contention goes to the pointer.
  // Ready is forced low while reset is held.
  always_comb begin
    can_load = (state_q == S_IDLE) | out_ready;
    win      = (&req_valid) ? ptr_q : req_valid[1];
    grant    = '0;
    if (can_load && rst_n && (|req_valid)) grant[win] = 1'b1;
    xfer     = |grant;
    sel_imm  = win ? req1_imm : req0_imm;
    sel_eop  = win ? req1_eop : req0_eop;
  end

  imm_ext_unit #(.IMM_W(IMM_W), .DATA_W(DATA_W)) u_ext (
    .imm_i (sel_imm),
    .eop_i (sel_eop),
    .ext_o (ext_res)
  );

  // Output-stage FSM: load on transfer, empty on drain without a refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= 1'b0;
      out_data_q <= '0;
      out_id_q   <= 1'b0;
    end else if (xfer) begin
      state_q    <= S_FULL;
      ptr_q      <= ~win;
      out_data_q <= ext_res;
      out_id_q   <= win;
    end else if (state_q == S_FULL && out_ready) begin
      state_q    <= S_IDLE;
    end
  end

  assign req_ready = grant;
  assign out_valid = (state_q == S_FULL);
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;

`ifdef EXT_ARB_STATS_EN
  logic [15:0] cnt0_q, cnt1_q;

  // Saturating transfer counters, one per requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (grant[0] && cnt0_q != 16'hFFFF) cnt0_q <= cnt0_q + 16'd1;
      if (grant[1] && cnt1_q != 16'hFFFF) cnt1_q <= cnt1_q + 16'd1;
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_ext_arbiter.sv
// Scoreboard bench for ext_arbiter: the driver predicts grants with a
// behavioural model and queues expected results; a monitor compares them
// whenever the output stage holds data.
module tb_ext_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [15:0] req0_imm = '0, req1_imm = '0;
  logic [1:0]  req0_eop = '0, req1_eop = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_id;
`ifdef EXT_ARB_STATS_EN
  logic [15:0] grant_cnt0, grant_cnt1;
`endif

  ext_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_imm(req0_imm), .req0_eop(req0_eop),
    .req1_imm(req1_imm), .req1_eop(req1_eop),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data),
`ifdef EXT_ARB_STATS_EN
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1),
`endif
    .out_id(out_id)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model state: is a result pending, who has priority, grant tallies.
  bit   m_full = 0;
  int   m_ptr  = 0;
  int   m_cnt0 = 0, m_cnt1 = 0;
  logic [32:0] sb_q[$];   // {id, data}

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] op);
    int s;
    s = int'($signed(imm));
    case (op)
      2'd0:    return 32'(s);
      2'd1:    return 32'(imm);
      2'd2:    return 32'(imm) << 16;
      default: return 32'(s * 4);
    endcase
  endfunction

  // One cycle of stimulus: drive after the edge, then predict and check grant.
  task automatic cyc(input logic [1:0] v, input logic [15:0] i0, input logic [1:0] e0,
                     input logic [15:0] i1, input logic [1:0] e1, input logic ord);
    bit canl;
    int w;
    logic [1:0] exp_rdy;
    @(posedge clk); #2;
    req_valid = v; req0_imm = i0; req0_eop = e0; req1_imm = i1; req1_eop = e1;
    out_ready = ord;
    #1;
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_full});
    canl = !m_full || ord;
    exp_rdy = 2'b00;
    w = -1;
    if (canl && v != 2'b00) begin
      if (v == 2'b11) w = m_ptr;
      else            w = (v == 2'b01) ? 0 : 1;
      exp_rdy[w] = 1'b1;
    end
    chk("req_ready", {30'd0, req_ready}, {30'd0, exp_rdy});
    chk("ready_onehot", {31'd0, req_ready == 2'b11}, 32'd0);
    if (w >= 0) begin
      sb_q.push_back({w[0], (w == 0) ? ref_ext(i0, e0) : ref_ext(i1, e1)});
      m_ptr  = 1 - w;
      m_full = 1;
      if (w == 0) m_cnt0++; else m_cnt1++;
    end else if (m_full && ord) begin
      m_full = 0;
    end
  endtask

  // Monitor: mid-cycle, the held result must match the queue head; pop on drain.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_out", {31'd0, out_valid}, 32'd0);
        end else begin
          chk("out_data", out_data, sb_q[0][31:0]);
          chk("out_id", {31'd0, out_id}, {31'd0, sb_q[0][32]});
          if (out_ready) void'(sb_q.pop_front());
        end
      end
    end
  end

  logic [1:0]  rv;
  logic [15:0] ri0, ri1;
  logic [1:0]  re0, re1;
  logic [1:0]  last_rdy;

  initial begin
    // Reset state
    #3;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_id", {31'd0, out_id}, 32'd0);
    req_valid = 2'b01;
    #1;
    chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
    req_valid = 2'b00;
    #10 rst_n = 1'b1;

    // Single requests, each op
    cyc(2'b01, 16'h8001, 2'b00, 16'h0, 2'b00, 1'b1);
    cyc(2'b00, 16'h0, 2'b00, 16'h0, 2'b00, 1'b1);
    chk("single_sext", out_data, 32'hFFFF8001);
    chk("single_sext_id", {31'd0, out_id}, 32'd0);
    cyc(2'b01, 16'h8001, 2'b01, 16'h0, 2'b00, 1'b1);
    cyc(2'b00, 16'h0, 2'b00, 16'h0, 2'b00, 1'b1);
    chk("single_zext", out_data, 32'h00008001);
    cyc(2'b01, 16'h8001, 2'b10, 16'h0, 2'b00, 1'b1);
    cyc(2'b00, 16'h0, 2'b00, 16'h0, 2'b00, 1'b1);
    chk("single_lui", out_data, 32'h80010000);
    cyc(2'b10, 16'h0, 2'b00, 16'hFFFF, 2'b11, 1'b1);
    cyc(2'b00, 16'h0, 2'b00, 16'h0, 2'b00, 1'b1);
    chk("single_br", out_data, 32'hFFFFFFFC);
    chk("single_br_id", {31'd0, out_id}, 32'd1);

    // Contention: alternating grants starting with requester 0
    for (int i = 0; i < 6; i++) begin
      cyc(2'b11, 16'(i), 2'(i), 16'(16'h7000 + i), 2'(3 - i), 1'b1);
      chk("rr_grant", {30'd0, req_ready}, (i % 2 == 0) ? 32'd1 : 32'd2);
    end
    cyc(2'b00, 16'h0, 2'b00, 16'h0, 2'b00, 1'b1);

    // Backpressure: load, stall 3 cycles with a pending request, then drain+load
    cyc(2'b01, 16'h1234, 2'b00, 16'h0, 2'b00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(2'b10, 16'h0, 2'b00, 16'h8000, 2'b01, 1'b0);
      chk("bp_data_stable", out_data, 32'h00001234);
    end
    cyc(2'b10, 16'h0, 2'b00, 16'h8000, 2'b01, 1'b1);
    cyc(2'b00, 16'h0, 2'b00, 16'h0, 2'b00, 1'b0);
    chk("bp_reload_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_reload_data", out_data, 32'h00008000);
    cyc(2'b00, 16'h0, 2'b00, 16'h0, 2'b00, 1'b1);

    // Reset mid-operation with pointer at 1
    cyc(2'b01, 16'h4444, 2'b00, 16'h0, 2'b00, 1'b0);
    cyc(2'b00, 16'h0, 2'b00, 16'h0, 2'b00, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    req_valid = 2'b11;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_req_ready", {30'd0, req_ready}, 32'd0);
    sb_q.delete();
    m_full = 0; m_ptr = 0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    req_valid = 2'b00;
    cyc(2'b11, 16'hA5A5, 2'b00, 16'h5A5A, 2'b01, 1'b1);
    chk("post_rst_grant", {30'd0, req_ready}, 32'd1);
    cyc(2'b00, 16'h0, 2'b00, 16'h0, 2'b00, 1'b1);

    // Randomized traffic honouring the hold rule
    rv = '0; ri0 = '0; ri1 = '0; re0 = '0; re1 = '0; last_rdy = '0;
    for (int n = 0; n < 400; n++) begin
      for (int r = 0; r < 2; r++) begin
        if (!(rv[r] && !last_rdy[r])) begin
          rv[r] = ($urandom_range(0, 3) != 0);
          if (r == 0) begin ri0 = 16'($urandom); re0 = 2'($urandom); end
          else        begin ri1 = 16'($urandom); re1 = 2'($urandom); end
        end
      end
      cyc(rv, ri0, re0, ri1, re1, 1'($urandom_range(0, 3) != 0));
      last_rdy = req_ready;
    end

    // Drain and confirm every queued result was seen
    for (int i = 0; i < 3; i++) cyc(2'b00, 16'h0, 2'b00, 16'h0, 2'b00, 1'b1);
    chk("sb_empty", sb_q.size(), 32'd0);

`ifdef EXT_ARB_STATS_EN
    chk("grant_cnt0", {16'd0, grant_cnt0}, (m_cnt0 > 65535) ? 32'hFFFF : 32'(m_cnt0));
    chk("grant_cnt1", {16'd0, grant_cnt1}, (m_cnt1 > 65535) ? 32'hFFFF : 32'(m_cnt1));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ext_arbiter.md
Name: ext_arbiter

Overview:
- Shares one immediate-extension unit between two requesters (e.g. decode lane 0 and lane 1, or decode and a branch-target helper).
- Round-robin arbitration with valid/ready handshakes per requester.
- The extended result goes to a one-deep registered output stage tagged with the winning requester's ID.
- Sits between instruction decode and the ALU/NPC operand muxes.

Parameters:
- NREQ, 2, number of requesters (fixed at 2 for this revision; the RR pointer is 1 bit).
- IMM_W, 16, immediate width.
- DATA_W, 32, extended result width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  2  per-requester request valid.
- req_ready  out  2  per-requester accept; a transfer happens when valid&ready.
- req0_imm  in  16  requester 0 immediate.
- req0_eop  in  2  requester 0 extension op.
- req1_imm  in  16  requester 1 immediate.
- req1_eop  in  2  requester 1 extension op.
- out_valid  out  1  result register holds valid data.
- out_ready  in  1  consumer accepts the result.
- out_data  out  32  extended immediate.
- out_id  out  1  ID of the requester that produced out_data.

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_data=0, out_id=0.
  - RR pointer=0 (requester 0 has priority first).
  - FSM=IDLE.
  - req_ready=0 while rst_n=0.
- Extension op encoding:
  - 00: sign-extend, {16{imm[15]},imm}.
  - 01: zero-extend, {16'h0,imm}.
  - 10: load-upper, {imm,16'h0}.
  - 11: branch offset, {14{imm[15]},imm,2'b00}.
  - All four codes are legal.
- FSM has two states:
  - IDLE (out_valid=0).
  - FULL (out_valid=1).
- can_load = (state==IDLE) | out_ready. The output stage accepts in the same cycle it drains, giving 1 result per cycle of sustained throughput.
- Grant (combinational, only when can_load):
  - If only one req_valid is high, grant it.
  - If both are high, grant the one not equal to the RR pointer's last winner (pointer = index holding priority).
  - req_ready[i] = can_load & grant[i].
  - At most one ready bit is high per cycle.
- On a transfer:
  - out_data <= extended(imm,eop) of the winner; out_id <= winner.
  - out_valid <= 1; the pointer moves to the other requester.
- When out_valid & out_ready with no transfer: out_valid <= 0 and state goes to IDLE. out_data/out_id hold their last values.
- Latency: 1 cycle from an accepted request to out_valid.
- Hold rules:
  - While out_valid & !out_ready, out_data and out_id stay stable.
  - No request is accepted in that condition.
  - A requester must hold valid, imm and eop until its ready.
- No starvation: with both requesters continuously valid and out_ready=1, grants alternate 0,1,0,1.
- A requester dropping valid before it is granted is allowed; no state is kept for it.
- rst_n asserted mid-operation: the pending result is discarded and the pointer returns to 0.

Optional Feature:
- Macro: EXT_ARB_STATS_EN.
- When defined, two extra outputs are present:
  - grant_cnt0 out 16
  - grant_cnt1 out 16
- Each counter is a saturating count (stops at 16'hFFFF) of transfers for its requester, reset to 0.
- When not defined, the ports and counters are absent and the behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - EOp localparams: EOP_SEXT=2'b00, EOP_ZEXT=2'b01, EOP_LUI=2'b10, EOP_BR=2'b11.
  - FSM state encodings: S_IDLE, S_FULL.
- One sub-module, imm_ext_unit: purely combinational (imm, eop) -> 32-bit result, instantiated once after the grant mux.

Test Plan:
- Single requests:
  - req0 valid, imm=16'h8001, eop=00, out_ready=1 -> next cycle out_data=32'hFFFF8001, out_id=0.
  - Repeat with eop=01 -> 32'h00008001.
  - Repeat with eop=10 -> 32'h80010000.
  - req1 imm=16'hFFFF, eop=11 -> 32'hFFFFFFFC, out_id=1.
- Contention: both valid continuously for 6 cycles, out_ready=1 -> out_id sequence 0,1,0,1,0,1; req_ready never 2'b11.
- Backpressure: out_ready=0 while FULL for 3 cycles -> req_ready=0, out_data/out_id stable. Raising out_ready with a pending request -> drain and load happen in the same cycle, out_valid stays 1.
- Reset mid-op: rst_n low while FULL with the pointer at 1 -> out_valid=0 immediately (async). After release, with both valid, the first grant is requester 0.
- EXT_ARB_STATS_EN: 5 grants to req0 and 3 to req1 -> grant_cnt0=5, grant_cnt1=3. Preload the counter near 16'hFFFF and force extra grants -> it saturates at 16'hFFFF.
